// File: rtl/wb_interconnect_1m_ns.sv
// wb_interconnect_1m_ns
// Wishbone B3 classic interconnect, one master to N_SLAVES slaves.
// Each slave owns a base/mask address window; the lowest index wins on
// overlap. Slave strobes, shared slave request fields and master
// terminations are all registered. Slaves see offset-relative addresses.
// Unmapped accesses are terminated with an error without touching a slave.
// Optional feature macro: WB_TIMEOUT_EN (bus-timeout watchdog that ends a
// stalled slave access with an error after TIMEOUT cycles).
module wb_interconnect_1m_ns #(
    parameter int N_SLAVES = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'hF000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = {32'hFFFF_FFF0, 32'hFF00_0000},
    parameter int TIMEOUT  = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    // master side
    input  logic [ADDR_W-1:0]          m_adr_i,
    input  logic [DATA_W-1:0]          m_dat_i,
    output logic [DATA_W-1:0]          m_dat_o,
    input  logic [DATA_W/8-1:0]        m_sel_i,
    input  logic                       m_cyc_i,
    input  logic                       m_stb_i,
    input  logic                       m_we_i,
    output logic                       m_ack_o,
    output logic                       m_err_o,
    output logic                       m_rty_o,
    // slave side
    output logic [ADDR_W-1:0]          s_adr_o,
    output logic [DATA_W-1:0]          s_dat_o,
    output logic [DATA_W/8-1:0]        s_sel_o,
    output logic                       s_we_o,
    output logic [N_SLAVES-1:0]        s_cyc_o,
    output logic [N_SLAVES-1:0]        s_stb_o,
    input  logic [N_SLAVES*DATA_W-1:0] s_dat_i,
    input  logic [N_SLAVES-1:0]        s_ack_i,
    input  logic [N_SLAVES-1:0]        s_err_i,
    input  logic [N_SLAVES-1:0]        s_rty_i
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;

    // decode results
    logic                 hit_any;
    logic [IDX_W-1:0]     hit_idx;
    logic [ADDR_W-1:0]    hit_mask;

    // selected slave response, combinational mux and its registered copy
    logic                 sel_ack;
    logic                 sel_err;
    logic                 sel_rty;
    logic [DATA_W-1:0]    sel_dat;
    logic                 ack_q;
    logic                 err_q;
    logic                 rty_q;
    logic [DATA_W-1:0]    dat_q;

`ifdef WB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TMO_W-1:0]     tmo_cnt;
`endif

    // Address decode: scan from the top so the lowest matching index wins.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        hit_mask = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_adr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_any  = 1'b1;
                hit_idx  = IDX_W'(i);
                hit_mask = SLAVE_MASK[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Pick out the response of the latched slave; all others are ignored.
    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_rty = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_ack = s_ack_i[i];
                sel_err = s_err_i[i];
                sel_rty = s_rty_i[i];
                sel_dat = s_dat_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register the selected slave's response; only live while in ACCESS so
    // stale terminations can never leak into the next transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rty_q <= 1'b0;
            dat_q <= '0;
        end else if (state == ACCESS) begin
            ack_q <= sel_ack;
            err_q <= sel_err;
            rty_q <= sel_rty;
            dat_q <= sel_dat;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rty_q <= 1'b0;
        end
    end

    // Transfer FSM with all bus outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            idx     <= '0;
            s_cyc_o <= '0;
            s_stb_o <= '0;
            s_adr_o <= '0;
            s_dat_o <= '0;
            s_sel_o <= '0;
            s_we_o  <= 1'b0;
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_rty_o <= 1'b0;
            m_dat_o <= '0;
`ifdef WB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    m_ack_o <= 1'b0;
                    m_err_o <= 1'b0;
                    m_rty_o <= 1'b0;
                    if (m_cyc_i && m_stb_i) begin
                        if (hit_any) begin
                            idx     <= hit_idx;
                            s_adr_o <= m_adr_i & ~hit_mask;
                            s_dat_o <= m_dat_i;
                            s_sel_o <= m_sel_i;
                            s_we_o  <= m_we_i;
                            s_cyc_o <= N_SLAVES'(1) << hit_idx;
                            s_stb_o <= N_SLAVES'(1) << hit_idx;
`ifdef WB_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                            state   <= ACCESS;
                        end else begin
                            // unmapped: error straight away, no slave involved
                            m_err_o <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end

                ACCESS: begin
                    if (!m_cyc_i) begin
                        // master abort: drop silently
                        s_cyc_o <= '0;
                        s_stb_o <= '0;
                        state   <= IDLE;
                    end else if (err_q || rty_q || ack_q) begin
                        s_cyc_o <= '0;
                        s_stb_o <= '0;
                        m_err_o <= err_q;
                        m_rty_o <= rty_q & ~err_q;
                        m_ack_o <= ack_q & ~err_q & ~rty_q;
                        if (!s_we_o) begin
                            m_dat_o <= dat_q;
                        end
                        state   <= RESP;
                    end
`ifdef WB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        // watchdog expired: give up on the slave
                        s_cyc_o <= '0;
                        s_stb_o <= '0;
                        m_err_o <= 1'b1;
                        state   <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    m_ack_o <= 1'b0;
                    m_err_o <= 1'b0;
                    m_rty_o <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    s_cyc_o <= '0;
                    s_stb_o <= '0;
                    m_ack_o <= 1'b0;
                    m_err_o <= 1'b0;
                    m_rty_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_interconnect_1m_ns.md
Name: wb_interconnect_1m_ns

Overview:
Parametrised Wishbone B3 classic interconnect: one master (CPU core) to N_SLAVES slaves (RAM, UART, timers, ...), with a base/mask address decode per slave. It generalises the fixed 1-master/2-slave arbiter. It adds:
- registered slave strobes and registered responses,
- offset-relative slave addresses,
- error termination for unmapped addresses,
- an optional bus-timeout watchdog.

It sits between the CPU's Wishbone master port and all on-chip peripherals.

Parameters:
N_SLAVES, 2, number of slave ports (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
SLAVE_BASE, {32'hF000_0000, 32'h0000_0000}, flattened N_SLAVES*ADDR_W base addresses; slave i is in bits [i*ADDR_W +: ADDR_W]
SLAVE_MASK, {32'hFFFF_FFF0, 32'hFF00_0000}, flattened N_SLAVES*ADDR_W decode masks
TIMEOUT, 255, watchdog cycles before error (only with WB_TIMEOUT_EN)

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous reset, active-high
m_adr_i  in  ADDR_W  master address
m_dat_i  in  DATA_W  master write data
m_dat_o  out  DATA_W  read data to master (registered)
m_sel_i  in  DATA_W/8  byte selects
m_cyc_i, m_stb_i, m_we_i  in  1 each  master cycle, strobe, write enable
m_ack_o, m_err_o, m_rty_o  out  1 each  registered termination pulses
s_adr_o  out  ADDR_W  latched offset address, shared by all slaves
s_dat_o  out  DATA_W  latched write data, shared by all slaves
s_sel_o  out  DATA_W/8  latched byte selects, shared
s_we_o  out  1  latched write enable, shared
s_cyc_o, s_stb_o  out  N_SLAVES each  one-hot per-slave cycle and strobe
s_dat_i  in  N_SLAVES*DATA_W  slave read data, flattened
s_ack_i, s_err_i, s_rty_i  in  N_SLAVES each  slave terminations

Behaviour:
- Reset (async, rst_i=1): FSM goes to IDLE.
  - All outputs 0: s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o, m_dat_o, s_adr_o, s_dat_o, s_sel_o, s_we_o.
  - Internal registers: timeout counter 0, selected index 0.
  - Reset mid-transfer aborts the transfer silently; no termination is issued.
- Decode (combinational, in IDLE): hit[i] = ((m_adr_i & MASK_i) == BASE_i). The lowest index wins when regions overlap.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Waits for m_cyc_i & m_stb_i.
  - On a hit: latch the index, s_adr_o = m_adr_i & ~MASK_i, and m_dat_i/m_sel_i/m_we_i. Assert s_cyc_o[idx] and s_stb_o[idx] from the next edge, then go to ACCESS.
  - On no hit: go to RESP with m_err_o=1 (termination 1 cycle after the strobe is sampled); no slave is touched.
- ACCESS:
  - Holds the one-hot strobes and samples s_*_i[idx] each cycle.
  - On a termination: drop s_cyc_o/s_stb_o at the next edge, set exactly one of m_ack_o/m_err_o/m_rty_o, latch m_dat_o = s_dat_i[idx] (reads only; held on writes), then go to RESP.
  - Simultaneous terminations: err > rty > ack.
  - Terminations from non-selected slaves are ignored.
- RESP:
  - The termination is high for exactly one cycle; all terminations clear at the next edge and the FSM returns to IDLE.
  - Latency: master sees the termination 2 cycles after the slave's ack (slave acking in its first strobe cycle → ack 3 cycles after the master strobe).
- Master abort: m_cyc_i=0 while in ACCESS → strobes drop at the next edge, return to IDLE, no termination.
- Back-to-back: m_stb_i still high in IDLE after RESP is decoded as a new transfer. At most one transfer is outstanding; no pipelining.
- m_dat_o holds the last read data until the next read completes.

Optional Feature:
WB_TIMEOUT_EN:
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without termination. When it reaches TIMEOUT, the slave strobes drop and the FSM goes to RESP with m_err_o=1. A late slave ack after that point is ignored.
- Undefined: no counter logic; ACCESS waits indefinitely for the slave (or a master abort).

Test Plan:
- Read 0x0000_1234; slave 0 acks 1 cycle after its strobe with 0xDEADBEEF → s_adr_o=0x001234, s_stb_o=2'b01; m_ack_o 1-cycle pulse 3 cycles after the strobe; m_dat_o=0xDEADBEEF.
- Write 0xF000_0004, data 0x55, sel 4'b0001 → s_stb_o=2'b10, s_adr_o=0x4, s_we_o=1, s_dat_o=0x55; m_ack_o pulses once; m_dat_o unchanged.
- Access 0x8000_0000 (unmapped) → no slave strobe; m_err_o pulses 1 cycle after the strobe.
- Slave 1 asserts err and ack in the same cycle → m_err_o=1, m_ack_o=0.
- With WB_TIMEOUT_EN, TIMEOUT=8, slave 0 never acks → m_err_o after 8 ACCESS cycles, strobes low; without the macro, strobes stay high for 1000 cycles.
- Master drops cyc at cycle 2 of ACCESS; separately, assert rst_i mid-ACCESS → both cases: outputs 0, no termination; the next transfer completes normally.
